// File: rtl/garip_sifre_cozucu.sv
// rtl/garip_sifre_cozucu.sv - serial cipher word receiver and decoder (invert / XOR key / rotate)

module garip_sifre_cozucu #(
  parameter int BIT = 4
) (
  input  logic           saat,
  input  logic           reset,
  input  logic           bit_girisi,
  input  logic           gecerli_giris,
  input  logic           mod,
  input  logic [2:0]     secim,
  output logic [BIT-1:0] veri,
  output logic           hazir,
  output logic           hata,
  output logic           mesgul
);

  // Counter must hold 0..BIT-1; one spare bit keeps the compare simple for any BIT.
  localparam int CW = $clog2(BIT + 1);

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    ALIM  = 2'd1,
    COZ   = 2'd2
  } durum_t;

  // Key has a 1 in every odd bit position (BIT=4 gives 4'b1010).
  function automatic logic [BIT-1:0] tek_anahtar();
    logic [BIT-1:0] k;
    for (int i = 0; i < BIT; i++) begin
      k[i] = ((i % 2) == 1);
    end
    return k;
  endfunction

  localparam logic [BIT-1:0] ANAHTAR = tek_anahtar();

  durum_t         durum_q, durum_d;
  logic [CW-1:0]  sayac_q, sayac_d;
  logic [BIT-1:0] kaydirma_q, kaydirma_d;
  logic           mod_q, mod_d;
  logic [2:0]     secim_q, secim_d;
  logic [BIT-1:0] veri_q, veri_d;
  logic           hazir_q, hazir_d;
  logic           hata_q, hata_d;

  logic [BIT-1:0] donmesiz;
  logic [BIT-1:0] anahtarsiz;
  logic [BIT-1:0] cozulen;

  // Decoder undoes the encoder steps in reverse order using the latched frame settings.
  always_comb begin
    donmesiz = kaydirma_q;
    if (secim_q[2]) begin
      // Encoder rotated left when mod=1, so undo with a right rotate (and vice versa).
      if (mod_q) begin
        donmesiz = {kaydirma_q[0], kaydirma_q[BIT-1:1]};
      end else begin
        donmesiz = {kaydirma_q[BIT-2:0], kaydirma_q[BIT-1]};
      end
    end
    anahtarsiz = secim_q[1] ? (donmesiz ^ ANAHTAR) : donmesiz;
    cozulen    = secim_q[0] ? ~anahtarsiz : anahtarsiz;
  end

  // Frame FSM: collect BIT serial bits, decode once, pulse hazir or hata.
  always_comb begin
    durum_d    = durum_q;
    sayac_d    = sayac_q;
    kaydirma_d = kaydirma_q;
    mod_d      = mod_q;
    secim_d    = secim_q;
    veri_d     = veri_q;
    hazir_d    = 1'b0;
    hata_d     = 1'b0;

    case (durum_q)
      BOSTA: begin
        if (gecerli_giris) begin
          // Bits arrive LSB first and are shifted in from the top, so the first bit
          // lands in position 0 after the remaining BIT-1 shifts.
          kaydirma_d = {bit_girisi, {(BIT-1){1'b0}}};
          sayac_d    = CW'(1);
          mod_d      = mod;
          secim_d    = secim;
          durum_d    = ALIM;
        end
      end

      ALIM: begin
        if (gecerli_giris) begin
          kaydirma_d = {bit_girisi, kaydirma_q[BIT-1:1]};
          sayac_d    = sayac_q + CW'(1);
          if (sayac_q == CW'(BIT - 1)) begin
            durum_d = COZ;
          end
        end else begin
          // A gap inside a frame aborts it; veri keeps the last good word.
          hata_d     = 1'b1;
          sayac_d    = '0;
          kaydirma_d = '0;
          durum_d    = BOSTA;
        end
      end

      COZ: begin
        veri_d  = cozulen;
        hazir_d = 1'b1;
        sayac_d = '0;
        durum_d = BOSTA;
      end

      default: begin
        sayac_d    = '0;
        kaydirma_d = '0;
        durum_d    = BOSTA;
      end
    endcase
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge saat or negedge reset) begin
    if (!reset) begin
      durum_q    <= BOSTA;
      sayac_q    <= '0;
      kaydirma_q <= '0;
      mod_q      <= 1'b0;
      secim_q    <= 3'b000;
      veri_q     <= '0;
      hazir_q    <= 1'b0;
      hata_q     <= 1'b0;
    end else begin
      durum_q    <= durum_d;
      sayac_q    <= sayac_d;
      kaydirma_q <= kaydirma_d;
      mod_q      <= mod_d;
      secim_q    <= secim_d;
      veri_q     <= veri_d;
      hazir_q    <= hazir_d;
      hata_q     <= hata_d;
    end
  end

  assign veri   = veri_q;
  assign hazir  = hazir_q;
  assign hata   = hata_q;
  assign mesgul = (durum_q != BOSTA);

endmodule

// File: tb/tb_garip_sifre_cozucu.sv
// tb/tb_garip_sifre_cozucu.sv - directed and exhaustive checks of the serial cipher decoder

module tb_garip_sifre_cozucu;

  logic       saat;
  logic       reset;
  logic       bit_girisi;
  logic       gecerli_giris;
  logic       mod;
  logic [2:0] secim;
  logic [3:0] veri;
  logic       hazir;
  logic       hata;
  logic       mesgul;

  int errors;
  int checks;

  garip_sifre_cozucu #(.BIT(4)) dut (
    .saat          (saat),
    .reset         (reset),
    .bit_girisi    (bit_girisi),
    .gecerli_giris (gecerli_giris),
    .mod           (mod),
    .secim         (secim),
    .veri          (veri),
    .hazir         (hazir),
    .hata          (hata),
    .mesgul        (mesgul)
  );

  initial saat = 1'b0;
  always #5 saat = ~saat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge saat);
    #1;
  endtask

  // Independent encoder: C = ROT(XK(INV(P))).
  function automatic logic [3:0] encode(input logic [3:0] p, input logic m, input logic [2:0] s);
    logic [3:0] x;
    x = p;
    if (s[0]) x = ~x;
    if (s[1]) x = x ^ 4'b1010;
    if (s[2]) x = m ? {x[2:0], x[3]} : {x[0], x[3:1]};
    return x;
  endfunction

  // Sends a full frame (mod/secim scrambled after bit 0), then checks the hazir cycle.
  // Leaves the DUT in BOSTA right after the hazir cycle, so frames run back to back
  // with exactly one idle (COZ) cycle between them.
  task automatic frame(input string tag, input logic [3:0] c, input logic m,
                       input logic [2:0] s, input logic [3:0] exp);
    for (int i = 0; i < 4; i++) begin
      bit_girisi    = c[i];
      gecerli_giris = 1'b1;
      mod           = (i == 0) ? m : ~m;
      secim         = (i == 0) ? s : ~s;
      tick();
      chk({tag, "_mesgul_rx"}, 32'(mesgul), 32'd1);
      chk({tag, "_hazir_rx"}, 32'(hazir), 32'd0);
    end
    gecerli_giris = 1'b0;
    bit_girisi    = 1'b0;
    tick();
    chk({tag, "_hazir"}, 32'(hazir), 32'd1);
    chk({tag, "_veri"}, 32'(veri), 32'(exp));
    chk({tag, "_hata"}, 32'(hata), 32'd0);
    chk({tag, "_mesgul_done"}, 32'(mesgul), 32'd0);
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    reset         = 1'b0;
    bit_girisi    = 1'b0;
    gecerli_giris = 1'b0;
    mod           = 1'b0;
    secim         = 3'b000;

    // Reset state, with valid asserted to show it is ignored in reset.
    gecerli_giris = 1'b1;
    tick();
    tick();
    chk("rst_veri", 32'(veri), 32'd0);
    chk("rst_hazir", 32'(hazir), 32'd0);
    chk("rst_hata", 32'(hata), 32'd0);
    chk("rst_mesgul", 32'(mesgul), 32'd0);
    gecerli_giris = 1'b0;
    reset = 1'b1;

    // Directed vectors.
    frame("v27", 4'd4, 1'b1, 3'd7, 4'd7);
    frame("v28a", 4'd9, 1'b0, 3'd3, 4'd12);
    frame("v28b", 4'd13, 1'b0, 3'd0, 4'd13);
    frame("v28c", 4'd1, 1'b0, 3'd4, 4'd2);

    // Back-to-back with one idle cycle: veri 7 then 12.
    frame("b2b1", 4'd4, 1'b1, 3'd7, 4'd7);
    frame("b2b2", 4'd9, 1'b0, 3'd3, 4'd12);
    tick();
    chk("b2b_hazir_drop", 32'(hazir), 32'd0);
    chk("b2b_veri_hold", 32'(veri), 32'd12);

    // Abort after 2 bits.
    gecerli_giris = 1'b1;
    mod           = 1'b1;
    secim         = 3'd7;
    bit_girisi    = 1'b1;
    tick();
    bit_girisi    = 1'b0;
    tick();
    gecerli_giris = 1'b0;
    tick();
    chk("abort_hata", 32'(hata), 32'd1);
    chk("abort_hazir", 32'(hazir), 32'd0);
    chk("abort_veri", 32'(veri), 32'd12);
    chk("abort_mesgul", 32'(mesgul), 32'd0);
    tick();
    chk("abort_hata_drop", 32'(hata), 32'd0);
    chk("abort_veri_hold", 32'(veri), 32'd12);
    tick();
    chk("abort_no_hazir", 32'(hazir), 32'd0);

    // Reset asserted between edges after bit 2.
    gecerli_giris = 1'b1;
    mod           = 1'b0;
    secim         = 3'd3;
    bit_girisi    = 1'b1;
    tick();
    bit_girisi    = 1'b0;
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("mrst_veri", 32'(veri), 32'd0);
    chk("mrst_hazir", 32'(hazir), 32'd0);
    chk("mrst_hata", 32'(hata), 32'd0);
    chk("mrst_mesgul", 32'(mesgul), 32'd0);
    tick();
    tick();
    chk("mrst_hold_mesgul", 32'(mesgul), 32'd0);
    chk("mrst_hold_hazir", 32'(hazir), 32'd0);
    gecerli_giris = 1'b0;
    reset = 1'b1;
    tick();
    chk("mrst_idle_mesgul", 32'(mesgul), 32'd0);
    chk("mrst_idle_hata", 32'(hata), 32'd0);
    frame("mrst_frame", 4'd9, 1'b0, 3'd3, 4'd12);

    // Exhaustive encode/decode round trip.
    for (int p = 0; p < 16; p++) begin
      for (int m = 0; m < 2; m++) begin
        for (int s = 0; s < 8; s++) begin
          frame("exh", encode(4'(p), 1'(m), 3'(s)), 1'(m), 3'(s), 4'(p));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/garip_sifre_cozucu.md
GARIP_SIFRE_COZUCU -- requirements
Module: garip_sifre_cozucu

Interface
REQ-001 SHALL have parameter: BIT, 4, cipher word width in bits; legal range 2..32.
REQ-002 SHALL have port: saat  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port: bit_girisi  input  1  serial cipher bit, LSB first.
REQ-005 SHALL have port: gecerli_giris  input  1  bit_girisi valid this cycle.
REQ-006 SHALL have port: mod  input  1  rotation direction used by the encoder: 1 = left, 0 = right.
REQ-007 SHALL have port: secim  input  3  transform select: [0] invert, [1] XOR key, [2] rotate by 1.
REQ-008 SHALL have port: veri  output  BIT  decoded plaintext word, registered.
REQ-009 SHALL have port: hazir  output  1  one-cycle pulse: veri updated this cycle.
REQ-010 SHALL have port: hata  output  1  one-cycle pulse: frame aborted.
REQ-011 SHALL have port: mesgul  output  1  high while a frame is in progress (states ALIM, COZ).

Function
REQ-012 SHALL implement FSM states BOSTA, ALIM, COZ.
REQ-013 BOSTA: on edge with gecerli_giris=1 SHALL store bit_girisi as cipher bit 0, latch mod and secim, set bit counter to 1, go to ALIM; otherwise stay.
REQ-014 ALIM: on each edge with gecerli_giris=1 SHALL store bit_girisi at cipher bit index = counter, increment counter; after storing bit BIT-1 go to COZ.
REQ-015 ALIM: edge with gecerli_giris=0 SHALL pulse hata for one cycle, discard partial word, leave veri unchanged, go to BOSTA.
REQ-016 mod/secim changes after the first bit SHALL NOT affect the frame in progress; only latched values are used.
REQ-017 COZ: on the next edge SHALL load veri with decoded word, pulse hazir for one cycle, return to BOSTA; gecerli_giris ignored in COZ.
REQ-018 Latency: hazir and new veri SHALL be visible one cycle after the edge sampling the last cipher bit.
REQ-019 Encoder definition: C = ROT(XK(INV(P))); INV = bitwise NOT if secim[0]; XK = XOR with key K if secim[1], K bit i = 1 for odd i (BIT=4: 4'b1010); ROT = rotate by 1 if secim[2], left when mod=1, right when mod=0; disabled steps are identity.
REQ-020 Decoder SHALL compute P = INV(XK(ROT^-1(C))): un-rotate in the opposite direction, then XOR K, then NOT, each per latched secim.
REQ-021 Decode SHALL be exact for all 2^BIT inputs and all 16 mod/secim combinations; no width truncation or extension.
REQ-022 Back-to-back frames: first bit of next frame SHALL be accepted on the edge after leaving COZ (minimum one idle cycle between frames).
REQ-023 veri SHALL hold its value between hazir pulses; hazir and hata SHALL never be high in the same cycle.

Reset
REQ-024 reset=0 SHALL immediately, independent of saat, force state BOSTA, counter 0, shift register 0, veri 0, hazir 0, hata 0, mesgul 0.
REQ-025 reset asserted mid-frame SHALL discard the frame with no hazir or hata pulse; after release decoder waits in BOSTA.
REQ-026 First frame after reset release SHALL be sampled from the first edge with reset=1 and gecerli_giris=1.

Verification
REQ-027 Reset then mod=1, secim=7, serial 0,0,1,0 (C=4) on 4 valid cycles -> hazir pulse one cycle later, veri=7, hata=0.
REQ-028 mod=0, secim=3, C=9 (bits 1,0,0,1) -> veri=12; secim=0, C=13 -> veri=13; mod=0, secim=4, C=1 -> veri=2.
REQ-029 gecerli_giris dropped after 2 bits -> hata pulse one cycle, no hazir, veri retains previous value, mesgul falls.
REQ-030 reset=0 asserted between clock edges after bit 2 -> outputs 0 immediately; following complete frame C=9, mod=0, secim=3 decodes to 12.
REQ-031 Two frames separated by exactly one idle cycle (C=4 mod=1 secim=7, then C=9 mod=0 secim=3) -> two hazir pulses, veri 7 then 12.
REQ-032 Exhaustive loop: bench-side encoder per REQ-019, all P, mod, secim -> decoded veri equals P every frame.
